// File: rtl/mem_trace_capture.sv
// rtl/mem_trace_capture.sv - PDP8 bus memory-access trace capture with record FIFO
// Optional: define TRACE_TIMESTAMP_EN to stamp each record with a 32-bit cycle count.
module mem_trace_capture #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    run,
  input  logic                    mem_finished,
  input  logic                    read_enable,
  input  logic                    write_enable,
  input  logic                    fetch_phase,
  input  logic [11:0]             address,
  input  logic [11:0]             read_data,
  input  logic [11:0]             write_data,
  input  logic [11:0]             mem_data,
  input  logic                    rec_ready,
  output logic                    rec_valid,
  output logic [1:0]              rec_type,
  output logic [11:0]             rec_address,
  output logic [11:0]             rec_bus_data,
  output logic [11:0]             rec_mem_data,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  output logic [CNT_W-1:0]        drop_count,
`ifdef TRACE_TIMESTAMP_EN
  output logic [31:0]             rec_timestamp,
`endif
  output logic                    trace_done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUNNING, DRAINING, DONE} state_t;
  state_t state, state_nxt;

  logic        mf_q, live_ev, pop, push_ok;
  logic        pend_valid, pend_load;
  logic [11:0] pend_addr, pend_bus, pend_md;
  logic        sk_valid, sk_load, sk_re, sk_we, sk_fp;
  logic [11:0] sk_addr, sk_rd, sk_wd, sk_md;
  logic        has_src, src_re, src_we, src_fp;
  logic [11:0] src_addr, src_rd, src_wd, src_md;
  logic        push_req;
  logic [1:0]  push_type;
  logic [11:0] push_addr, push_bus, push_md;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]  type_mem [DEPTH];
  logic [11:0] addr_mem [DEPTH];
  logic [11:0] bus_mem  [DEPTH];
  logic [11:0] md_mem   [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q, pend_ts, sk_ts, src_ts, push_ts;
  logic [31:0] ts_mem [DEPTH];
`endif

  assign live_ev   = mem_finished & ~mf_q & ((state == RUNNING) | (state == DRAINING));
  assign rec_valid = (fifo_level != '0);
  assign pop       = rec_valid & rec_ready;
  assign push_ok   = push_req & ((fifo_level != FULL_LVL) | pop);
  assign trace_done = (state == DONE);

  // A pending dual-access write owns this cycle's push; a coincident event waits in the skid.
  always_comb begin
    src_re = read_enable;  src_we = write_enable; src_fp = fetch_phase;
    src_addr = address;    src_rd = read_data;    src_wd = write_data; src_md = mem_data;
    has_src = live_ev & ~pend_valid;
    sk_load = live_ev & (pend_valid | sk_valid);
`ifdef TRACE_TIMESTAMP_EN
    src_ts = ts_q;
`endif
    if (sk_valid && !pend_valid) begin
      has_src = 1'b1;
      src_re = sk_re;     src_we = sk_we; src_fp = sk_fp;
      src_addr = sk_addr; src_rd = sk_rd; src_wd = sk_wd; src_md = sk_md;
`ifdef TRACE_TIMESTAMP_EN
      src_ts = sk_ts;
`endif
    end
    push_req = 1'b0; push_type = 2'd0; pend_load = 1'b0;
    push_addr = src_addr; push_bus = src_rd; push_md = src_md;
`ifdef TRACE_TIMESTAMP_EN
    push_ts = pend_valid ? pend_ts : src_ts;
`endif
    if (pend_valid) begin
      push_req = 1'b1; push_type = 2'd2;
      push_addr = pend_addr; push_bus = pend_bus; push_md = pend_md;
    end else if (has_src && src_re) begin
      push_req = 1'b1; push_type = {1'b0, src_fp}; pend_load = src_we;
    end else if (has_src && src_we) begin
      push_req = 1'b1; push_type = 2'd2; push_bus = src_wd;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      mf_q <= 1'b0;
      pend_valid <= 1'b0; pend_addr <= '0; pend_bus <= '0; pend_md <= '0;
      sk_valid <= 1'b0; sk_re <= 1'b0; sk_we <= 1'b0; sk_fp <= 1'b0;
      sk_addr <= '0; sk_rd <= '0; sk_wd <= '0; sk_md <= '0;
      wr_ptr <= '0; rd_ptr <= '0; fifo_level <= '0;
      overflow <= 1'b0; drop_count <= '0;
`ifdef TRACE_TIMESTAMP_EN
      ts_q <= '0; pend_ts <= '0; sk_ts <= '0;
`endif
    end else begin
      mf_q <= mem_finished;
      pend_valid <= pend_load;
      if (pend_load) begin
        pend_addr <= src_addr; pend_bus <= src_wd; pend_md <= src_md;
`ifdef TRACE_TIMESTAMP_EN
        pend_ts <= src_ts;
`endif
      end
      if (sk_load) begin
        sk_valid <= 1'b1; sk_re <= read_enable; sk_we <= write_enable; sk_fp <= fetch_phase;
        sk_addr <= address; sk_rd <= read_data; sk_wd <= write_data; sk_md <= mem_data;
`ifdef TRACE_TIMESTAMP_EN
        sk_ts <= ts_q;
`endif
      end else if (!pend_valid) begin
        sk_valid <= 1'b0;
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
`ifdef TRACE_TIMESTAMP_EN
      ts_q <= ts_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      type_mem[wr_ptr] <= push_type;
      addr_mem[wr_ptr] <= push_addr;
      bus_mem[wr_ptr]  <= push_bus;
      md_mem[wr_ptr]   <= push_md;
`ifdef TRACE_TIMESTAMP_EN
      ts_mem[wr_ptr]   <= push_ts;
`endif
    end
  end

  // Record fields read as zero whenever nothing is presented.
  assign rec_type     = rec_valid ? type_mem[rd_ptr] : '0;
  assign rec_address  = rec_valid ? addr_mem[rd_ptr] : '0;
  assign rec_bus_data = rec_valid ? bus_mem[rd_ptr]  : '0;
  assign rec_mem_data = rec_valid ? md_mem[rd_ptr]   : '0;
`ifdef TRACE_TIMESTAMP_EN
  assign rec_timestamp = rec_valid ? ts_mem[rd_ptr] : '0;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (run) state_nxt = RUNNING;
      RUNNING:  if (!run) state_nxt = DRAINING;
      DRAINING: if (fifo_level == '0 && !pend_valid && !sk_valid) state_nxt = DONE;
      DONE:     if (run) state_nxt = RUNNING;
      default:  state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_trace_capture.sv
// tb/tb_mem_trace_capture.sv - scoreboard bench for mem_trace_capture with queue-based reference model
module tb_mem_trace_capture;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_DONE = 3;

  logic clock = 1'b0, resetN = 1'b1, run = 1'b0, mem_finished = 1'b0;
  logic read_enable = 1'b0, write_enable = 1'b0, fetch_phase = 1'b0, rec_ready = 1'b0;
  logic [11:0] address = '0, read_data = '0, write_data = '0, mem_data = '0;
  logic rec_valid, overflow, trace_done;
  logic [1:0] rec_type;
  logic [11:0] rec_address, rec_bus_data, rec_mem_data;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CNT_W-1:0] drop_count;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] rec_timestamp;
`endif

  mem_trace_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .resetN(resetN), .run(run), .mem_finished(mem_finished),
    .read_enable(read_enable), .write_enable(write_enable), .fetch_phase(fetch_phase),
    .address(address), .read_data(read_data), .write_data(write_data), .mem_data(mem_data),
    .rec_ready(rec_ready), .rec_valid(rec_valid), .rec_type(rec_type),
    .rec_address(rec_address), .rec_bus_data(rec_bus_data), .rec_mem_data(rec_mem_data),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count),
`ifdef TRACE_TIMESTAMP_EN
    .rec_timestamp(rec_timestamp),
`endif
    .trace_done(trace_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  t;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] m;
    logic [31:0] ts;
  } rec_t;

  rec_t exp_q[$];
  int   mdl_lvl, mdl_drops, phase, pop_cnt;
  bit   mdl_ovf, mf_prev, pend_have;
  rec_t pend_rec;
  logic [31:0] mdl_ts;
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_lvl = 0; mdl_drops = 0; mdl_ovf = 0; phase = PH_IDLE;
    mf_prev = 0; pend_have = 0; mdl_ts = '0;
  endtask

  // Reference: FIFO contents as a queue of records, one decision per clock edge.
  task automatic model_step();
    bit pop, ev, cap, have, pend0;
    int lvl0;
    rec_t r;
    lvl0 = mdl_lvl; pend0 = pend_have;
    pop = (mdl_lvl > 0) && rec_ready;
    ev = mem_finished && !mf_prev;
    mf_prev = mem_finished;
    cap = (phase == PH_RUN) || (phase == PH_DRAIN);
    have = 0; r = '0;
    if (pend_have) begin
      r = pend_rec; have = 1; pend_have = 0;
    end else if (ev && cap) begin
      if (read_enable) begin
        r = '{fetch_phase ? 2'd1 : 2'd0, address, read_data, mem_data, mdl_ts};
        have = 1;
        if (write_enable) begin
          pend_rec = '{2'd2, address, write_data, mem_data, mdl_ts};
          pend_have = 1;
        end
      end else if (write_enable) begin
        r = '{2'd2, address, write_data, mem_data, mdl_ts};
        have = 1;
      end
    end
    if (have) begin
      if (mdl_lvl < DEPTH || pop) begin
        exp_q.push_back(r); mdl_lvl++;
      end else begin
        mdl_ovf = 1;
        if (mdl_drops < (1 << CNT_W) - 1) mdl_drops++;
      end
    end
    if (pop) mdl_lvl--;
    case (phase)
      PH_IDLE:  if (run) phase = PH_RUN;
      PH_RUN:   if (!run) phase = PH_DRAIN;
      PH_DRAIN: if (lvl0 == 0 && !pend0) phase = PH_DONE;
      default:  if (run) phase = PH_RUN;
    endcase
    mdl_ts = mdl_ts + 1;
  endtask

  always @(posedge clock) if (resetN) model_step();

  always @(negedge clock) begin
    rec_t r;
    if (resetN) begin
      if (rec_valid && rec_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("rec_unexpected", 1, 0);
        end else begin
          r = exp_q.pop_front();
          check("rec_fields", {rec_type, rec_address, rec_bus_data, rec_mem_data},
                {r.t, r.a, r.b, r.m});
`ifdef TRACE_TIMESTAMP_EN
          check("rec_timestamp", rec_timestamp, r.ts);
`endif
        end
      end
      check("fifo_level", fifo_level, mdl_lvl);
      check("overflow", overflow, mdl_ovf);
      check("drop_count", drop_count, mdl_drops);
      check("trace_done", trace_done, phase == PH_DONE);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic ev(input bit re, input bit we, input bit fp,
                    input logic [11:0] a, input logic [11:0] rd,
                    input logic [11:0] wd, input logic [11:0] md);
    read_enable = re; write_enable = we; fetch_phase = fp;
    address = a; read_data = rd; write_data = wd; mem_data = md;
    mem_finished = 1; tick();
    mem_finished = 0; tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, rec_valid, 0);
    check({tag, "_fields"}, {rec_type, rec_address, rec_bus_data, rec_mem_data}, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_drops"}, drop_count, 0);
    check({tag, "_done"}, trace_done, 0);
  endtask

  initial begin
    int p0;
    pop_cnt = 0;
    model_reset();
    #1 resetN = 0; #1;
    check_all_zero("reset");
    tick(2); resetN = 1; rec_ready = 1;
    tick(); run = 1; tick(2);

    // fetch read
    read_enable = 1; write_enable = 0; fetch_phase = 1; address = 12'o0200;
    read_data = 12'o7300; mem_data = 12'o7300; mem_finished = 1; tick();
    check("fetch_valid", rec_valid, 1);
    check("fetch_type", rec_type, 1);
    check("fetch_addr", rec_address, 12'o0200);
    check("fetch_bus", rec_bus_data, 12'o7300);
    mem_finished = 0; tick(2);

    // write
    read_enable = 0; write_enable = 1; fetch_phase = 0; address = 12'o0010;
    write_data = 12'o1234; mem_data = 12'o0000; mem_finished = 1; tick();
    check("write_type", rec_type, 2);
    check("write_bus", rec_bus_data, 12'o1234);
    check("write_mem", rec_mem_data, 12'o0000);
    mem_finished = 0; tick(2);

    // dual access
    rec_ready = 0; read_enable = 1; write_enable = 1; address = 12'o0456;
    read_data = 12'o1111; write_data = 12'o2222; mem_data = 12'o3333;
    mem_finished = 1; tick();
    check("dual_lvl1", fifo_level, 1);
    check("dual_head", rec_type, 0);
    mem_finished = 0; tick();
    check("dual_lvl2", fifo_level, 2);
    rec_ready = 1; tick(4);

    // overflow: 18 single-record events into a stalled FIFO
    rec_ready = 0; p0 = pop_cnt;
    for (int i = 0; i < 18; i++) begin
      bit re;
      re = $urandom_range(0, 1);
      ev(re, !re, $urandom_range(0, 1), 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
    end
    check("ovf_level", fifo_level, 16);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 2);
    rec_ready = 1; tick(20);
    check("ovf_drained", pop_cnt - p0, 16);

    // level held high
    p0 = pop_cnt; read_enable = 1; write_enable = 0; mem_finished = 1; tick(5);
    mem_finished = 0; tick(4);
    check("held_one_rec", pop_cnt - p0, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      mem_finished = 1'($urandom); read_enable = 1'($urandom);
      write_enable = 1'($urandom); fetch_phase = 1'($urandom);
      address = 12'($urandom); read_data = 12'($urandom);
      write_data = 12'($urandom); mem_data = 12'($urandom);
      rec_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    mem_finished = 0; run = 1; rec_ready = 1; tick(25);

    // run ends with three queued, drain to done
    rec_ready = 0;
    for (int i = 0; i < 3; i++) ev(1, 0, 0, 12'(i + 1), 12'(i + 8), 0, 12'(i));
    run = 0; tick(); rec_ready = 1;
    for (int i = 0; i < 40 && !trace_done; i++) tick();
    check("done_reached", trace_done, 1);
    ev(1, 0, 1, 12'o7777, 12'o1, 0, 0);
    check("done_ignores_ev", fifo_level, 0);

    // reset during drain
    run = 1; tick(); rec_ready = 0;
    for (int i = 0; i < 3; i++) ev(0, 1, 0, 12'(i), 0, 12'(i + 5), 0);
    run = 0; tick(2);
    resetN = 0; #1;
    check_all_zero("midreset");
    model_reset();
    tick(); resetN = 1; tick(3);

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_trace_capture.md
Name: mem_trace_capture

Overview:
- Synthesizable monitor on the PDP8 main bus, downstream of the memory controller.
- On each memory-access completion it classifies the access (fetch, data read, write) and captures a trace record (type, address, bus data, memory array data).
- Records are buffered in a FIFO and drained by the emulator transactor over a valid/ready stream, which then writes the memory trace file.
- Replaces per-access polling of bus signals in the testbench with a clocked, lossless-when-drained capture path.

Parameters:
- DEPTH, 16, FIFO entries (power of two, >= 4)
- CNT_W, 16, width of drop counter

Ports:
- clock  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- run  in  1  CPU run indicator (front panel run LED)
- mem_finished  in  1  memory controller access-complete strobe
- read_enable  in  1  bus read request
- write_enable  in  1  bus write request
- fetch_phase  in  1  high when controller state is FETCH_2
- address  in  12  bus address
- read_data  in  12  data returned on bus read
- write_data  in  12  data driven on bus write
- mem_data  in  12  memory array contents at address
- rec_ready  in  1  transactor accepts record
- rec_valid  out  1  record available
- rec_type  out  2  0=read, 1=fetch, 2=write
- rec_address  out  12  record address
- rec_bus_data  out  12  read_data or write_data
- rec_mem_data  out  12  mem_data at capture
- fifo_level  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: a record was dropped
- drop_count  out  CNT_W  dropped records, saturating
- trace_done  out  1  run ended and FIFO drained

Behaviour:
- Reset (async, resetN=0): FIFO empty, fifo_level=0, rec_valid=0, rec_* =0, overflow=0, drop_count=0, trace_done=0, state IDLE, pending write cleared, mem_finished edge register=0.
- Edge detect: mem_finished_q registered each clock; event = mem_finished & ~mem_finished_q. A level held high produces one event.
- Capture only in RUNNING or DRAINING; events in IDLE/DONE ignored.
- On event: read_enable -> push type fetch_phase?1:0 with bus_data=read_data. write_enable only -> push type 2 with bus_data=write_data. Neither -> no record.
- Both enables on one event: read record pushed on event edge; write record (fields latched at event) pushed on next edge. A new event during that cycle is serviced after the pending write (one-entry skid), never lost.
- Push timing: record written at the clock edge sampling the event; rec_valid rises after that same edge if FIFO was empty (first-word-fall-through).
- Pop: rec_valid & rec_ready at an edge removes head; next entry presented after that edge.
- Full: push accepted if not full or a pop occurs the same edge; otherwise record dropped, overflow set (sticky until reset), drop_count += 1, saturating at all-ones.
- Empty with simultaneous push/pop: no pop (rec_valid=0); push lands normally.
- Pointers wrap modulo DEPTH; fifo_level ranges 0..DEPTH.
- FSM: IDLE -(run=1)-> RUNNING; RUNNING -(run=0)-> DRAINING; DRAINING -(FIFO empty, no pending write)-> DONE; DONE -(run=1)-> RUNNING. trace_done=1 only in DONE (registered).
- Reset mid-operation discards all buffered records immediately.

Optional Feature:
- TRACE_TIMESTAMP_EN defined: 32-bit free-running cycle counter (reset 0, +1 every clock, wraps). Its value at the event edge is stored per record and presented on added output port rec_timestamp [31:0]. Deferred write of a dual access carries the event timestamp.
- Undefined: no counter, no rec_timestamp port, FIFO width excludes it.

Test Plan:
- run=1, one event read_enable=1, fetch_phase=1, address=12'o0200, read_data=12'o7300 -> next cycle rec_valid=1, rec_type=1, rec_address=0200, rec_bus_data=7300.
- Event write_enable=1, address=12'o0010, write_data=12'o1234, mem_data=12'o0000 -> rec_type=2, rec_bus_data=1234, rec_mem_data=0000.
- Event with both enables -> two records in order: type 0 then type 2, same address; fifo_level steps 1 then 2.
- rec_ready=0, 18 events with DEPTH=16 -> fifo_level=16, overflow=1, drop_count=2; then drain -> exactly 16 records in order.
- mem_finished held high 5 cycles -> exactly one record.
- run 1->0 with 3 queued, rec_ready=1 -> trace_done rises 1 cycle after last pop; resetN=0 mid-drain -> all outputs 0 immediately.
